// File: rtl/ex_md_pkg.sv
// ---------------------------------------------------------------------------
// ex_md_pkg
// Shared definitions for the EX-stage multiply/divide unit:
//   - md_state_e   : control FSM states (IDLE / CALC / DONE)
//   - F3_*         : FUNC3 encodings of the M-extension operations
//   - op1_is_signed / op2_is_signed : which operand is treated as two's
//                    complement for a given FUNC3
// ---------------------------------------------------------------------------
package ex_md_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // MUL only needs the low product half, which is identical for signed and
    // unsigned operands, so it is run unsigned and never needs a fixup.
    function automatic logic op1_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV)  || (f3 == F3_REM);
    endfunction

    function automatic logic op2_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// ---------------------------------------------------------------------------
// md_iter_core
// One iteration of the unsigned multiply / divide datapath (purely
// combinational; the accumulator registers live in the parent).
//
// Multiply (shift-add): {acc_hi, acc_lo} is the partial product with the
//   unconsumed multiplier bits in acc_lo.  If acc_lo[0] is set, operand
//   (multiplicand) is added to acc_hi, then the whole pair shifts right.
// Divide (restoring): acc_hi is the partial remainder, acc_lo holds the
//   remaining dividend bits (MSB first) and collects quotient bits at the
//   LSB.  operand is the divisor.
//
// Ports:
//   is_div      : 1 = divide step, 0 = multiply step
//   acc_hi      : high accumulator (product high / remainder)
//   acc_lo      : low accumulator  (multiplier / dividend->quotient)
//   operand     : multiplicand or divisor magnitude
//   acc_hi_next : high accumulator after this iteration
//   acc_lo_next : low accumulator after this iteration
// ---------------------------------------------------------------------------
module md_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc_hi,
    input  logic [XLEN-1:0] acc_lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] acc_hi_next,
    output logic [XLEN-1:0] acc_lo_next
);

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] div_shift;
    logic [XLEN:0] div_diff;
    logic          div_ge;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, operand};
        // The partial remainder is always below the divisor, so the shifted
        // value is below 2*divisor.  With its MSB set it must exceed the
        // divisor; otherwise the wrap bit of the difference is the borrow.
        div_ge    = div_shift[XLEN] | ~div_diff[XLEN];

        if (is_div) begin
            if (div_ge) begin
                acc_hi_next = div_diff[XLEN-1:0];
                acc_lo_next = {acc_lo[XLEN-2:0], 1'b1};
            end else begin
                acc_hi_next = div_shift[XLEN-1:0];
                acc_lo_next = {acc_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_hi_next = mul_sum[XLEN:1];
            acc_lo_next = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
// Iterative RV32M-style multiply/divide unit for the EX stage.  Operands are
// converted to magnitudes when the op is signed, run through XLEN iterations
// of md_iter_core, and sign-corrected on the way into RESULT.  Divide by zero
// and signed overflow bypass the iterations and complete in one cycle.
//
// Ports:
//   CLK    : clock, all state changes on the rising edge
//   RESET  : synchronous active-high reset
//   START  : op request (level, held by ID/EX)
//   FUNC3  : operation select (see ex_md_pkg F3_*)
//   OP1    : rs1 value
//   OP2    : rs2 value
//   HOLD   : downstream freeze, keeps a finished result in DONE
//   FLUSH  : kill the in-flight op, back to IDLE
//   RESULT : registered result
//   VALID  : RESULT valid (high exactly in DONE)
//   STALL  : freeze IF/ID/EX while an op is being accepted or computed
//   BUSY   : FSM not in IDLE
// ---------------------------------------------------------------------------
module ex_muldiv_unit
    import ex_md_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      FUNC3,
    input  logic [XLEN-1:0] OP1,
    input  logic [XLEN-1:0] OP2,
    input  logic            HOLD,
    input  logic            FLUSH,
    output logic [XLEN-1:0] RESULT,
    output logic            VALID,
    output logic            STALL,
    output logic            BUSY
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state_reg;
    logic [2:0]      func3_reg;
    logic            neg_res_reg;   // negate product / quotient
    logic            neg_rem_reg;   // negate remainder (dividend sign)
    logic [XLEN-1:0] acc_hi_reg;
    logic [XLEN-1:0] acc_lo_reg;
    logic [XLEN-1:0] opb_reg;       // multiplicand or divisor magnitude
    logic [XLEN-1:0] result_reg;
    logic [CNT_W-1:0] cnt_reg;

    // ---------------- operand decode at acceptance ----------------
    logic            op1_neg;
    logic            op2_neg;
    logic [XLEN-1:0] op1_mag;
    logic [XLEN-1:0] op2_mag;
    logic            div_by_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_result;

    always_comb begin
        op1_neg     = op1_is_signed(FUNC3) & OP1[XLEN-1];
        op2_neg     = op2_is_signed(FUNC3) & OP2[XLEN-1];
        op1_mag     = op1_neg ? -OP1 : OP1;
        op2_mag     = op2_neg ? -OP2 : OP2;

        div_by_zero = FUNC3[2] & (OP2 == '0);
        // Only the signed divide/remainder ops (FUNC3[0] = 0) can overflow.
        div_ovf     = FUNC3[2] & ~FUNC3[0] & (OP1 == MIN_NEG) & (OP2 == '1);
        special     = div_by_zero | div_ovf;

        // FUNC3[1] separates remainder from quotient within the divide group.
        if (div_by_zero) begin
            special_result = FUNC3[1] ? OP1 : '1;
        end else begin
            special_result = FUNC3[1] ? '0 : OP1;
        end
    end

    // ---------------- iteration datapath ----------------
    logic [XLEN-1:0] acc_hi_next;
    logic [XLEN-1:0] acc_lo_next;

    md_iter_core #(
        .XLEN        (XLEN)
    ) u_core (
        .is_div      (func3_reg[2]),
        .acc_hi      (acc_hi_reg),
        .acc_lo      (acc_lo_reg),
        .operand     (opb_reg),
        .acc_hi_next (acc_hi_next),
        .acc_lo_next (acc_lo_next)
    );

    // ---------------- sign fixup of the final iteration ----------------
    // Taken from the core's next-state outputs so RESULT is loaded on the
    // same edge that completes the last iteration.
    logic [2*XLEN-1:0] prod_raw;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_result;

    always_comb begin
        prod_raw = {acc_hi_next, acc_lo_next};
        prod_fix = neg_res_reg ? -prod_raw : prod_raw;
        quot_fix = neg_res_reg ? -acc_lo_next : acc_lo_next;
        rem_fix  = neg_rem_reg ? -acc_hi_next : acc_hi_next;

        case (func3_reg)
            F3_MUL:                         final_result = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:   final_result = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:                final_result = quot_fix;
            default:                        final_result = rem_fix;
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg   <= ST_IDLE;
            func3_reg   <= '0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            acc_hi_reg  <= '0;
            acc_lo_reg  <= '0;
            opb_reg     <= '0;
            result_reg  <= '0;
            cnt_reg     <= '0;
        end else if (FLUSH) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (START) begin
                        func3_reg   <= FUNC3;
                        neg_res_reg <= op1_neg ^ op2_neg;
                        neg_rem_reg <= op1_neg;
                        acc_hi_reg  <= '0;
                        if (FUNC3[2]) begin
                            acc_lo_reg <= op1_mag;   // dividend
                            opb_reg    <= op2_mag;   // divisor
                        end else begin
                            acc_lo_reg <= op2_mag;   // multiplier
                            opb_reg    <= op1_mag;   // multiplicand
                        end
                        if (special) begin
                            result_reg <= special_result;
                            state_reg  <= ST_DONE;
                        end else begin
                            cnt_reg   <= CNT_W'(XLEN);
                            state_reg <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc_hi_reg <= acc_hi_next;
                    acc_lo_reg <= acc_lo_next;
                    cnt_reg    <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        result_reg <= final_result;
                        state_reg  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!HOLD) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign RESULT = result_reg;
    assign VALID  = (state_reg == ST_DONE);
    assign BUSY   = (state_reg != ST_IDLE);
    assign STALL  = ~RESET & (((state_reg == ST_IDLE) & START & ~FLUSH) |
                              (state_reg == ST_CALC));

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_unit
// Directed vector table, hand-written HOLD / FLUSH / RESET sequences and
// randomized ops checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_unit;
    import ex_md_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [2:0]  FUNC3;
    logic [31:0] OP1;
    logic [31:0] OP2;
    logic        HOLD;
    logic        FLUSH;
    logic [31:0] RESULT;
    logic        VALID;
    logic        STALL;
    logic        BUSY;

    always #5 CLK = ~CLK;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .FUNC3  (FUNC3),
        .OP1    (OP1),
        .OP2    (OP2),
        .HOLD   (HOLD),
        .FLUSH  (FLUSH),
        .RESULT (RESULT),
        .VALID  (VALID),
        .STALL  (STALL),
        .BUSY   (BUSY)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] last_result  = 32'h0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[17];

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_result(input logic [2:0] f,
                                                 input logic [31:0] a,
                                                 input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        up  = {32'h0, a} * {32'h0, b};
        case (f)
            3'd0: return up[31:0];
            3'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp[63:32];
            end
            3'd2: begin
                sp = longint'($signed(a)) * longint'({32'h0, b});
                return sp[63:32];
            end
            3'd3: return up[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return a;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        if (f[2] && (b == 0)) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        return 33;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one op in the current cycle (cycle 0) and follow it to DONE.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input string name);
        int cyc;
        bit stall_ok;
        bit hold_ok;
        FUNC3 = f;
        OP1   = a;
        OP2   = b;
        START = 1'b1;
        HOLD  = 1'b0;
        FLUSH = 1'b0;
        #1;
        cyc      = 0;
        stall_ok = 1'b1;
        hold_ok  = 1'b1;
        while (!VALID && cyc < 100) begin
            if (STALL !== 1'b1) stall_ok = 1'b0;
            if (RESULT !== last_result) hold_ok = 1'b0;
            tick();
            cyc++;
        end
        check({name, "/valid"}, 32'(VALID), 32'd1);
        check({name, "/latency"}, 32'(cyc), 32'(exp_lat));
        check({name, "/result"}, RESULT, exp_res);
        check({name, "/stall_busy"}, 32'(stall_ok), 32'd1);
        check({name, "/result_held"}, 32'(hold_ok), 32'd1);
        check({name, "/stall_done"}, 32'(STALL), 32'd0);
        $display("[TB] %s f3=%0d op1=%h op2=%h result=%h lat=%0d",
                 name, f, a, b, RESULT, cyc);
        last_result = exp_res;
        START = 1'b0;
        tick();
        check({name, "/idle_valid"}, 32'(VALID), 32'd0);
        check({name, "/idle_busy"}, 32'(BUSY), 32'd0);
    endtask

    task automatic watch_no_valid(input int n, input string name);
        int vcount;
        vcount = 0;
        repeat (n) begin
            if (VALID) vcount++;
            tick();
        end
        check(name, 32'(vcount), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed vectors
        vecs[0]  = '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7x-3"};
        vecs[1]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max"};
        vecs[2]  = '{F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh_m1"};
        vecs[3]  = '{F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, "div_-7/2"};
        vecs[4]  = '{F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, "rem_-7/2"};
        vecs[5]  = '{F3_DIVU,   32'd100,        32'd0,         32'hFFFF_FFFF, 1,  "divu_by0"};
        vecs[6]  = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf"};
        vecs[7]  = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1,  "rem_ovf"};
        vecs[8]  = '{F3_REMU,   32'd100,        32'd0,         32'd100,       1,  "remu_by0"};
        vecs[9]  = '{F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu_m1"};
        vecs[10] = '{F3_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7/-2"};
        vecs[11] = '{F3_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         33, "rem_7/-2"};
        vecs[12] = '{F3_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33, "divu_max/1"};
        vecs[13] = '{F3_REM,    32'h8000_0000,  32'd0,         32'h8000_0000, 1,  "rem_by0"};
        vecs[14] = '{F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, "mulh_min2"};
        vecs[15] = '{F3_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 33, "divu_nonovf"};
        vecs[16] = '{F3_REMU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33, "remu_nonovf"};

        // ---------------- reset ----------------
        RESET = 1'b1;
        START = 1'b1;
        FUNC3 = F3_MUL;
        OP1   = 32'd7;
        OP2   = 32'd3;
        HOLD  = 1'b0;
        FLUSH = 1'b0;
        tick();
        tick();
        tick();
        check("reset/stall", 32'(STALL), 32'd0);
        check("reset/valid", 32'(VALID), 32'd0);
        check("reset/busy", 32'(BUSY), 32'd0);
        check("reset/result", RESULT, 32'd0);
        START = 1'b0;
        RESET = 1'b0;
        tick();
        last_result = 32'h0;

        // FLUSH beats START in IDLE
        START = 1'b1;
        FLUSH = 1'b1;
        #1;
        check("flush_idle/stall", 32'(STALL), 32'd0);
        tick();
        check("flush_idle/busy", 32'(BUSY), 32'd0);
        START = 1'b0;
        FLUSH = 1'b0;
        tick();

        // ---------------- directed table ----------------
        for (int i = 0; i < 17; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].res,
                   vecs[i].lat, vecs[i].name);
        end

        // ---------------- HOLD in DONE ----------------
        begin
            int          vcnt;
            int          cyc;
            logic [31:0] exp_h;
            exp_h = model_result(F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
            FUNC3 = F3_MULHU;
            OP1   = 32'h1234_5678;
            OP2   = 32'h9ABC_DEF0;
            START = 1'b1;
            #1;
            cyc = 0;
            while (!VALID && cyc < 100) begin
                tick();
                cyc++;
            end
            check("hold/latency", 32'(cyc), 32'd33);
            vcnt = VALID ? 1 : 0;
            HOLD = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                if (VALID) vcnt++;
                check($sformatf("hold/result%0d", k), RESULT, exp_h);
                check($sformatf("hold/stall%0d", k), 32'(STALL), 32'd0);
            end
            HOLD  = 1'b0;
            START = 1'b0;
            tick();
            check("hold/valid_cycles", 32'(vcnt), 32'd4);
            check("hold/idle_valid", 32'(VALID), 32'd0);
            check("hold/idle_busy", 32'(BUSY), 32'd0);
            $display("[TB] hold_seq result=%h valid_cycles=%0d", RESULT, vcnt);
            last_result = exp_h;
        end

        // ---------------- FLUSH at CALC cycle 10 ----------------
        FUNC3 = F3_DIVU;
        OP1   = 32'd1000;
        OP2   = 32'd7;
        START = 1'b1;
        tick();
        check("flush/calc_busy", 32'(BUSY), 32'd1);
        check("flush/calc_stall", 32'(STALL), 32'd1);
        repeat (9) tick();
        FLUSH = 1'b1;
        tick();
        check("flush/busy", 32'(BUSY), 32'd0);
        check("flush/valid", 32'(VALID), 32'd0);
        check("flush/result_kept", RESULT, last_result);
        FLUSH = 1'b0;
        START = 1'b0;
        $display("[TB] flush_seq busy=%0d valid=%0d", BUSY, VALID);
        watch_no_valid(40, "flush/no_valid");
        run_op(F3_DIVU, 32'd1000, 32'd7, 32'd142, 33, "after_flush");

        // ---------------- RESET at CALC cycle 5 ----------------
        FUNC3 = F3_MUL;
        OP1   = 32'd12345;
        OP2   = 32'd678;
        START = 1'b1;
        repeat (5) tick();
        RESET = 1'b1;
        tick();
        check("rst_mid/busy", 32'(BUSY), 32'd0);
        check("rst_mid/valid", 32'(VALID), 32'd0);
        check("rst_mid/result", RESULT, 32'd0);
        check("rst_mid/stall", 32'(STALL), 32'd0);
        RESET = 1'b0;
        START = 1'b0;
        last_result = 32'h0;
        $display("[TB] reset_seq busy=%0d valid=%0d result=%h", BUSY, VALID, RESULT);
        watch_no_valid(40, "rst_mid/no_valid");
        run_op(F3_MUL, 32'd12345, 32'd678, 32'd8369910, 33, "after_reset");

        // ---------------- randomized ops ----------------
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f;
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            f   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'd1;
                3: b = 32'($urandom_range(1, 20));
                4: a = 32'($urandom_range(0, 50));
                default: ;
            endcase
            run_op(f, a, b, model_result(f, a, b), model_latency(f, a, b),
                   $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (even, >= 8).
REQ-002 SHALL have parameter CNT_W, default $clog2(XLEN)+1, iteration counter width.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port START  input  1  request for an M-extension op; level, held by the ID/EX register.
REQ-006 SHALL have port FUNC3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have ports OP1, OP2  input  XLEN each  forwarded rs1 and rs2 values.
REQ-008 SHALL have port HOLD  input  1  downstream freeze (memory busywait).
REQ-009 SHALL have port FLUSH  input  1  branch-taken kill of the in-flight op.
REQ-010 SHALL have port RESULT  output  XLEN  registered result.
REQ-011 SHALL have port VALID  output  1  RESULT is valid this cycle.
REQ-012 SHALL have port STALL  output  1  pipeline must freeze IF/ID/EX.
REQ-013 SHALL have port BUSY  output  1  FSM not in IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 IDLE & START & !FLUSH SHALL latch FUNC3/operands, go to CALC, or go to DONE if a special case applies.
REQ-016 Special cases SHALL be: divisor 0 -> DIV/DIVU all-ones, REM/REMU = OP1; signed overflow (OP1 = -2^(XLEN-1), OP2 = -1) -> DIV = OP1, REM = 0.
REQ-017 CALC SHALL run exactly XLEN iterations: shift-add multiply or restoring divide, on magnitudes for signed operands.
REQ-018 On the CALC->DONE edge, RESULT SHALL be loaded with the sign-corrected result.
REQ-019 Sign correction: quotient negated iff operand signs differ; remainder takes the dividend's sign.
REQ-020 MUL SHALL return the low XLEN bits of the 2*XLEN product; MULH/MULHSU/MULHU SHALL return the high XLEN bits.
REQ-021 Latency SHALL be: normal op START accepted in cycle 0 -> VALID in cycle XLEN+1; special case -> VALID in cycle 1.
REQ-022 VALID SHALL be high exactly while in DONE.
REQ-023 DONE & !HOLD SHALL go to IDLE next cycle; DONE & HOLD SHALL remain in DONE with RESULT stable.
REQ-024 STALL SHALL equal (IDLE & START & !FLUSH) | CALC; it is low in DONE.
REQ-025 START SHALL be ignored in CALC and DONE, so the same instruction is never re-issued.
REQ-026 FLUSH in any state SHALL force IDLE next cycle with VALID low; FLUSH has priority over START and HOLD.
REQ-027 RESULT SHALL hold its last value in IDLE and CALC.

Reset
REQ-028 RESET SHALL force IDLE, RESULT = 0, VALID = 0, BUSY = 0, iteration counter = 0; STALL is 0 while RESET is high.
REQ-029 RESET mid-CALC SHALL abort the op; no VALID pulse follows.

Structure
REQ-030 Package ex_md_pkg SHALL hold the state enum and the FUNC3 op constants.
REQ-031 Sub-module md_iter_core SHALL hold the per-iteration shift/add/subtract datapath; the FSM, special-case logic and sign fixup stay in ex_muldiv_unit.

Verification
REQ-032 MUL: OP1 = 7, OP2 = -3 -> VALID in cycle 33, RESULT = 0xFFFFFFEB; STALL high in cycles 0-32.
REQ-033 MULHU: 0xFFFFFFFF x 0xFFFFFFFF -> RESULT = 0xFFFFFFFE; MULH of the same operands -> RESULT = 0.
REQ-034 DIV: -7 / 2 -> 0xFFFFFFFD; REM: -7 / 2 -> 0xFFFFFFFF; DIVU: 100 / 0 -> 0xFFFFFFFF at cycle 1.
REQ-035 DIV: 0x80000000 / -1 -> RESULT = 0x80000000, VALID in cycle 1; REM of the same -> 0.
REQ-036 HOLD high for 3 cycles in DONE -> VALID high 4 cycles, RESULT stable; START still high -> no second op.
REQ-037 FLUSH at CALC cycle 10, or RESET at CALC cycle 5 -> IDLE next cycle, no VALID, next START gives a correct result.
